// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU result stage and its neighbours.
//   FLAG_N/Z/C/V  : bit positions inside the NZCV flag vector
//   DEF_WIDTH     : default datapath / result width
//   DEF_FLAG_W    : default flag width
//   DEF_RD_W      : default register-file destination address width
//   alu_wb_t      : writeback payload {result, rd, wr_en} at default widths
//   make_nzcv     : helper that packs four flag bits into NZCV order
// ---------------------------------------------------------------------------
package alu_pkg;

   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

   localparam int DEF_WIDTH  = 32;
   localparam int DEF_FLAG_W = 4;
   localparam int DEF_RD_W   = 4;

   typedef struct packed {
      logic [DEF_WIDTH-1:0] result;
      logic [DEF_RD_W-1:0]  rd;
      logic                 wr_en;
   } alu_wb_t;

   function automatic logic [DEF_FLAG_W-1:0] make_nzcv(input logic n,
                                                      input logic z,
                                                      input logic c,
                                                      input logic v);
      logic [DEF_FLAG_W-1:0] f;
      f         = '0;
      f[FLAG_N] = n;
      f[FLAG_Z] = z;
      f[FLAG_C] = c;
      f[FLAG_V] = v;
      return f;
   endfunction

endpackage

// File: rtl/alu_result_stage_if.sv
// ---------------------------------------------------------------------------
// alu_result_stage_if
// Bundles the two valid/ready channels of the ALU result stage.
//   in_*   : ALU -> stage  (valid, result, new_flag, s, rd, wr_en; ready back)
//   out_*  : stage -> writeback (valid, result, rd, wr_en; ready back)
// Modports:
//   master : the environment side (drives ALU outputs and writeback ready)
//   slave  : the stage itself
// ---------------------------------------------------------------------------
interface alu_result_stage_if
   import alu_pkg::*;
#(
   parameter int WIDTH  = DEF_WIDTH,
   parameter int FLAG_W = DEF_FLAG_W,
   parameter int RD_W   = DEF_RD_W
) ();

   logic              in_valid;
   logic              in_ready;
   logic [WIDTH-1:0]  in_result;
   logic [FLAG_W-1:0] in_new_flag;
   logic              in_s;
   logic [RD_W-1:0]   in_rd;
   logic              in_wr_en;

   logic              out_valid;
   logic              out_ready;
   logic [WIDTH-1:0]  out_result;
   logic [RD_W-1:0]   out_rd;
   logic              out_wr_en;

   modport master (
      output in_valid,
      output in_result,
      output in_new_flag,
      output in_s,
      output in_rd,
      output in_wr_en,
      input  in_ready,
      input  out_valid,
      input  out_result,
      input  out_rd,
      input  out_wr_en,
      output out_ready
   );

   modport slave (
      input  in_valid,
      input  in_result,
      input  in_new_flag,
      input  in_s,
      input  in_rd,
      input  in_wr_en,
      output in_ready,
      output out_valid,
      output out_result,
      output out_rd,
      output out_wr_en,
      input  out_ready
   );

endinterface

// File: rtl/alu_result_stage_skid_fifo2.sv
// ---------------------------------------------------------------------------
// skid_fifo2
// Generic 2-entry valid/ready FIFO with synchronous flush.
//   clk, rst_n   : rising-edge clock, synchronous active-low reset
//   flush        : drop every held entry at the next edge (beats push/pop)
//   push_valid/push_ready/push_data : write side
//   pop_valid/pop_ready/pop_data    : read side, head held in registers
//   count        : entries currently held (0..2)
// push_ready depends only on the stored count, never on pop_ready, so the
// upstream is not stalled combinationally by downstream back-pressure.
// ---------------------------------------------------------------------------
module skid_fifo2 #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         flush,
   input  logic         push_valid,
   output logic         push_ready,
   input  logic [W-1:0] push_data,
   output logic         pop_valid,
   input  logic         pop_ready,
   output logic [W-1:0] pop_data,
   output logic [1:0]   count
);

   logic [W-1:0] mem [2];
   logic         wr_ptr;
   logic         rd_ptr;
   logic [1:0]   cnt;
   logic         push;
   logic         pop;

   assign push_ready = (cnt != 2'd2);
   assign pop_valid  = (cnt != 2'd0);
   assign push       = push_valid & push_ready;
   assign pop        = pop_valid & pop_ready;
   assign pop_data   = mem[rd_ptr];
   assign count      = cnt;

   // Storage is cleared on reset so the head never shows X, and is only
   // written on a real (non-flushed) push.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         mem[0] <= '0;
         mem[1] <= '0;
      end else if (push && !flush) begin
         mem[wr_ptr] <= push_data;
      end
   end

   // Pointers are single bits, so toggling them is the 1 -> 0 wrap.
   always_ff @(posedge clk) begin
      if (!rst_n || flush) begin
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr <= ~wr_ptr;
         end
         if (pop) begin
            rd_ptr <= ~rd_ptr;
         end
      end
   end

   // Simultaneous push and pop only happens at count 1 and leaves it there.
   always_ff @(posedge clk) begin
      if (!rst_n || flush) begin
         cnt <= 2'd0;
      end else begin
         unique case ({push, pop})
            2'b10:   cnt <= cnt + 2'd1;
            2'b01:   cnt <= cnt - 2'd1;
            default: cnt <= cnt;
         endcase
      end
   end

endmodule

// File: rtl/alu_result_stage.sv
// ---------------------------------------------------------------------------
// alu_result_stage
// Captures ALU results into a 2-entry skid buffer for register writeback and
// owns the architectural NZCV flag register that feeds every ALU unit.
//   clk, rst_n : rising-edge clock, synchronous active-low reset
//   flush      : discard buffered entries and any same-cycle push
//   bus        : alu_result_stage_if.slave (in_* from ALU, out_* to writeback)
//   flag_q     : architectural NZCV, [3]=N [2]=Z [1]=C [0]=V
//   occupancy  : entries held (0..2)
// Flags change when an instruction is accepted, not when it writes back, so
// writeback back-pressure never delays flag visibility to the next ALU op.
// ---------------------------------------------------------------------------
module alu_result_stage
   import alu_pkg::*;
#(
   parameter int WIDTH  = DEF_WIDTH,
   parameter int FLAG_W = DEF_FLAG_W,
   parameter int RD_W   = DEF_RD_W,
   parameter int DEPTH  = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   alu_result_stage_if.slave bus,
   output logic [FLAG_W-1:0] flag_q,
   output logic [1:0]        occupancy
);

   localparam int PAY_W = WIDTH + RD_W + 1;

   logic [PAY_W-1:0] push_data;
   logic [PAY_W-1:0] head_data;
   logic             fifo_push_ready;
   logic             fifo_pop_valid;
   logic [1:0]       fifo_count;
   logic             accept;

   // Payload order is {result, rd, wr_en}; wr_en=0 entries still travel so
   // flag-only ops keep their place in the writeback order.
   assign push_data = {bus.in_result, bus.in_rd, bus.in_wr_en};

   skid_fifo2 #(
      .W (PAY_W)
   ) u_fifo (
      .clk        (clk),
      .rst_n      (rst_n),
      .flush      (flush),
      .push_valid (bus.in_valid),
      .push_ready (fifo_push_ready),
      .push_data  (push_data),
      .pop_valid  (fifo_pop_valid),
      .pop_ready  (bus.out_ready),
      .pop_data   (head_data),
      .count      (fifo_count)
   );

   assign bus.in_ready   = fifo_push_ready;
   assign bus.out_valid  = fifo_pop_valid;
   assign bus.out_result = head_data[PAY_W-1 -: WIDTH];
   assign bus.out_rd     = head_data[RD_W:1];
   assign bus.out_wr_en  = head_data[0];
   assign occupancy      = fifo_count;

   assign accept = bus.in_valid & fifo_push_ready;

   // A flushed accept is void, so its flag update is suppressed as well.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         flag_q <= '0;
      end else if (accept && !flush && bus.in_s) begin
         flag_q <= bus.in_new_flag;
      end
   end

endmodule

// File: doc/alu_result_stage.md
Name: alu_result_stage

Overview:
- Pipeline stage directly downstream of the ALU shift/arith units (LSR, ADD, ...): captures {Result, New_Flag} plus the writeback destination and hands them to register-file writeback through a valid/ready handshake.
- Owns the architectural NZCV flag register. Its output `flag_q` is the `Flag` input to every ALU unit, closing the flag loop.
- Contains a 2-entry skid buffer, so ALU issue is not stalled combinationally by writeback back-pressure.

Parameters:
- WIDTH, 32, datapath / result width
- FLAG_W, 4, flag width; bit order [3]=N, [2]=Z, [1]=C, [0]=V
- RD_W, 4, register-file destination address width
- DEPTH, 2, skid buffer entries (fixed at 2; other values unsupported)

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- flush  input  1  discard all buffered entries (branch/exception)
- in_valid  input  1  ALU output valid
- in_ready  output  1  stage can accept this cycle
- in_result  input  WIDTH  ALU Result
- in_new_flag  input  FLAG_W  ALU New_Flag
- in_s  input  1  set-flags bit of the instruction
- in_rd  input  RD_W  destination register
- in_wr_en  input  1  instruction writes a register
- out_valid  output  1  head entry valid
- out_ready  input  1  writeback consumes head
- out_result  output  WIDTH  head result
- out_rd  output  RD_W  head destination
- out_wr_en  output  1  head write enable
- flag_q  output  FLAG_W  architectural NZCV, fed to ALU Flag input
- occupancy  output  2  entries held (0..2)

Behaviour:
- Reset: one clock, synchronous, active-low.
  - While rst_n=0 at a rising edge: flag_q=0000, occupancy=0, out_valid=0, out_result=0, out_rd=0, out_wr_en=0, both buffer entries and pointers cleared.
  - Reset mid-transfer drops all entries; no partial writeback.
- Handshake:
  - Accept (push) = in_valid & in_ready. Consume (pop) = out_valid & out_ready.
  - in_ready = (occupancy != 2). It is a registered function of state and never depends on out_ready.
  - out_valid = (occupancy != 0). Head fields come from registers and are stable while out_valid=1 and out_ready=0.
- Latency: an accepted entry is visible at the outputs the cycle after acceptance when the buffer was empty (1-cycle latency). Entries are strictly FIFO.
- Buffer: 2 entries with a 1-bit write pointer and a 1-bit read pointer, both wrapping 1 -> 0. Occupancy next-state:
  - push only: +1
  - pop only: -1
  - push and pop: unchanged; allowed only at occupancy 1 (at 0 there is no pop, at 2 there is no push)
  - neither: unchanged
- Flag register:
  - On accept with in_s=1: flag_q <= in_new_flag at that edge, so the next ALU operation sees the updated flags one cycle after acceptance.
  - Accept with in_s=0: flag_q unchanged.
  - Flags update at acceptance, not at writeback. Back-pressure never delays flag visibility.
- Flush:
  - At the edge: occupancy <= 0 and pointers <= 0.
  - Flush has priority over a same-cycle push or pop. The pushed entry is dropped, and its flag update is also suppressed.
  - flag_q otherwise retains its value.
  - in_ready is still computed from pre-flush occupancy; the upstream treats a flushed cycle's accept as void.
- An entry with in_wr_en=0 is still buffered and popped in order (keeps ordering for flag-only ops); writeback ignores it.
- X-safety: buffer contents update only on push, so the head must never present stale X after reset.

Decomposition:
- Shared package `alu_pkg`:
  - localparams FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0
  - WIDTH/FLAG_W defaults
  - packed struct `alu_wb_t` {result, rd, wr_en}
- One natural sub-module: `skid_fifo2`, a generic 2-entry valid/ready FIFO parameterized on payload width, with flush. Flag register logic stays in `alu_result_stage`.

Test Plan:
- Reset/flow: after rst_n low 2 cycles then high, push {result=1, flag=0000, s=1, rd=3, wr_en=1} (LSR 3>>1) with out_ready=1 -> next cycle out_valid=1, out_result=1, out_rd=3; flag_q=0000.
- Flag gating:
  - push flag=0100, s=1 -> flag_q=0100 next cycle.
  - then push flag=1000, s=0 -> flag_q stays 0100.
- Back-pressure: out_ready=0, push results 10, 20 -> occupancy=2, in_ready=0; third in_valid ignored. Then out_ready=1 -> outputs 10 then 20 on consecutive cycles, in_ready=1 after the first pop.
- Simultaneous push/pop at occupancy 1 (head=5, push 7) -> occupancy stays 1, out_result=7 next cycle; pointer wrap checked over 6 such cycles.
- Flush priority: occupancy 2, flush=1 with in_valid=1, flag=1111, s=1 -> occupancy=0, out_valid=0, flag_q unchanged.
- Reset mid-operation: occupancy 2, out_ready=0, assert rst_n=0 one cycle -> all outputs zero, flag_q=0000, in_ready=1.
